// File: rtl/mem_arbiter.sv
// Arbitrates a single-port synchronous memory between fetch (if_*) and load/store (d_*).
// Ports: clk/rst, fetch req/gnt/rvalid/rdata, data req/we/be/addr/wdata/gnt/rvalid/rdata, mem_* strobe bus, busy.
module mem_arbiter #(
   parameter int ADDR_WIDTH   = 32,
   parameter int DATA_WIDTH   = 32,
   parameter int MEM_LATENCY  = 1,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    if_req,
   input  logic [ADDR_WIDTH-1:0]   if_addr,
   output logic                    if_gnt,
   output logic                    if_rvalid,
   output logic [DATA_WIDTH-1:0]   if_rdata,
   input  logic                    d_req,
   input  logic                    d_we,
   input  logic [DATA_WIDTH/8-1:0] d_be,
   input  logic [ADDR_WIDTH-1:0]   d_addr,
   input  logic [DATA_WIDTH-1:0]   d_wdata,
   output logic                    d_gnt,
   output logic                    d_rvalid,
   output logic [DATA_WIDTH-1:0]   d_rdata,
   output logic                    mem_req,
   output logic                    mem_we,
   output logic [DATA_WIDTH/8-1:0] mem_be,
   output logic [ADDR_WIDTH-1:0]   mem_addr,
   output logic [DATA_WIDTH-1:0]   mem_wdata,
   input  logic [DATA_WIDTH-1:0]   mem_rdata,
   output logic                    busy
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
   localparam int SW = $clog2(STARVE_LIMIT + 1);

   state_t          state, state_n;
   logic [CW-1:0]   cnt;
   logic [SW-1:0]   streak;
   logic            sel_d;
   logic            wr_q;
   logic            pick_d;
   logic            start;
   logic            last_wait;

   // Data wins a tie unless fetch has been passed over STARVE_LIMIT times in a row.
   always_comb begin
      state_n   = state;
      start     = (state == IDLE) && (if_req || d_req);
      last_wait = (state == WAIT) && (cnt == CW'(MEM_LATENCY - 1));
      pick_d    = d_req && (!if_req || (streak < SW'(STARVE_LIMIT)));
      unique case (state)
         IDLE:    if (if_req || d_req) state_n = ISSUE;
         ISSUE:   state_n = WAIT;
         WAIT:    if (last_wait) state_n = RESP;
         RESP:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   // Outputs are registered from the next-state view so they line up with the state.
   always_ff @(posedge clk) begin
      if (rst) begin
         if_gnt    <= 1'b0;
         if_rvalid <= 1'b0;
         if_rdata  <= '0;
         d_gnt     <= 1'b0;
         d_rvalid  <= 1'b0;
         d_rdata   <= '0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_be    <= '0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         busy      <= 1'b0;
         cnt       <= '0;
         streak    <= '0;
         sel_d     <= 1'b0;
         wr_q      <= 1'b0;
      end else begin
         busy      <= (state_n != IDLE);
         mem_req   <= start;
         if_gnt    <= start && !pick_d;
         d_gnt     <= start && pick_d;
         mem_we    <= start && pick_d && d_we;
         mem_be    <= start ? (pick_d ? d_be : '1) : '0;
         if_rvalid <= last_wait && !sel_d;
         d_rvalid  <= last_wait && sel_d;

         if (start) begin
            sel_d     <= pick_d;
            wr_q      <= pick_d && d_we;
            mem_addr  <= pick_d ? d_addr : if_addr;
            mem_wdata <= pick_d ? d_wdata : '0;
            if (pick_d) begin
               if (streak < SW'(STARVE_LIMIT)) streak <= streak + 1'b1;
            end else begin
               streak <= '0;
            end
         end

         if (state == ISSUE)
            cnt <= '0;
         else if ((state == WAIT) && !last_wait)
            cnt <= cnt + 1'b1;

         // A write acknowledge returns zero rather than whatever the memory drives.
         if (last_wait) begin
            if (sel_d) d_rdata  <= wr_q ? '0 : mem_rdata;
            else       if_rdata <= mem_rdata;
         end
      end
   end

endmodule
